// File: rtl/parser_seg_gather.sv
// Gathers the first C_NUM_SEGS beats of each AXI-Stream packet into one wide
// entry (beat-0 tuser and VLAN ID included) and queues it in a fall-through
// FIFO. Beats past the gather window are dropped up to tlast.
module parser_seg_gather #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS           = 4,
  parameter int C_VLANID_WIDTH       = 12,
  parameter int C_FIFO_DEPTH_BITS    = 4
) (
  input  logic                                       axis_clk,
  input  logic                                       aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]            s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]           s_axis_tkeep,
  input  logic                                       s_axis_tvalid,
  input  logic                                       s_axis_tlast,
  output logic                                       s_axis_tready,
  output logic [C_NUM_SEGS*C_S_AXIS_DATA_WIDTH-1:0]  m_segs_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]            m_segs_tuser,
  output logic [C_VLANID_WIDTH-1:0]                  m_segs_vlan,
  output logic [3:0]                                 m_segs_nsegs,
  output logic                                       m_segs_valid,
  input  logic                                       m_segs_ready,
  output logic [31:0]                                pkt_cnt
);

  localparam int W    = C_S_AXIS_DATA_WIDTH;
  localparam int KW   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int TU   = C_S_AXIS_TUSER_WIDTH;
  localparam int VL   = C_VLANID_WIDTH;
  localparam int DB   = C_FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << DB;
  localparam int SW   = C_NUM_SEGS * W;
  localparam int EW   = SW + TU + VL + 4;
  localparam logic [3:0]  LAST_IDX = 4'(C_NUM_SEGS - 1);
  localparam logic [DB:0] CNT_ONE  = (DB+1)'(1);
  localparam logic [DB-1:0] PTR_ONE = DB'(1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH} state_t;

  state_t          r_state, w_state_next;
  logic [3:0]      r_idx, w_idx_next;
  logic            w_push, w_pop, w_hs, w_full, w_last_seg;

  logic [SW-1:0]   r_segs, w_segs_next;
  logic [TU-1:0]   r_tuser, w_tuser_next;
  logic [VL-1:0]   r_vlan, w_vlan_next, w_vlan_beat;
  logic [W-1:0]    w_beat_masked;
  logic [3:0]      w_nsegs;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [DB-1:0]   r_wr_ptr, r_rd_ptr;
  logic [DB:0]     r_count;
  logic [EW-1:0]   w_wr_entry, w_rd_entry;

  // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign w_full        = r_count[DB];
  assign s_axis_tready = (r_state == S_FLUSH) ? 1'b1 : !w_full;
  assign w_hs          = s_axis_tvalid & s_axis_tready;
  assign w_last_seg    = (r_idx == LAST_IDX);

  // Zero out bytes whose keep bit is clear.
  for (genvar gi = 0; gi < KW; gi++) begin : g_mask
    assign w_beat_masked[gi*8 +: 8] = s_axis_tkeep[gi] ? s_axis_tdata[gi*8 +: 8] : 8'h00;
  end

  // Segment image including the current beat; a new packet starts from all-zero.
  for (genvar gi = 0; gi < C_NUM_SEGS; gi++) begin : g_segs
    assign w_segs_next[gi*W +: W] = (r_idx == 4'(gi)) ? w_beat_masked :
                                    ((r_state == S_IDLE) ? '0 : r_segs[gi*W +: W]);
  end

  assign w_vlan_beat  = VL'({s_axis_tdata[115:112], s_axis_tdata[127:120]});
  assign w_tuser_next = (r_state == S_IDLE) ? s_axis_tuser : r_tuser;
  assign w_vlan_next  = (r_state == S_IDLE) ? w_vlan_beat  : r_vlan;
  assign w_nsegs      = r_idx + 4'd1;
  assign w_wr_entry   = {w_nsegs, w_vlan_next, w_tuser_next, w_segs_next};

  // Next-state, beat index and FIFO push decision.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_hs) begin
          if (s_axis_tlast || w_last_seg) begin
            w_push       = 1'b1;
            w_idx_next   = 4'd0;
            w_state_next = s_axis_tlast ? S_IDLE : S_FLUSH;
          end else begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = S_COLLECT;
          end
        end
      end
      S_FLUSH: begin
        if (w_hs && s_axis_tlast) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and beat index.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Partial gather storage; stale contents are harmless since beat 0 clears it.
  always_ff @(posedge axis_clk) begin
    if (w_hs && (r_state != S_FLUSH)) begin
      r_segs  <= w_segs_next;
      r_tuser <= w_tuser_next;
      r_vlan  <= w_vlan_next;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge axis_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  assign m_segs_valid = (r_count != '0);
  assign w_pop        = m_segs_valid & m_segs_ready;
  assign w_rd_entry   = r_mem[r_rd_ptr];
  assign {m_segs_nsegs, m_segs_vlan, m_segs_tuser, m_segs_tdata} = w_rd_entry;

  // FIFO pointers, occupancy and packet counter.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      pkt_cnt  <= 32'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        pkt_cnt  <= pkt_cnt + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_parser_seg_gather.sv
// Directed bench for parser_seg_gather with default parameters.
module tb_parser_seg_gather;

  localparam int W  = 256;
  localparam int TU = 128;
  localparam int NS = 4;
  localparam int VL = 12;
  localparam int KW = W / 8;

  logic              axis_clk = 1'b0;
  logic              aresetn;
  logic [W-1:0]      s_axis_tdata;
  logic [TU-1:0]     s_axis_tuser;
  logic [KW-1:0]     s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [NS*W-1:0]   m_segs_tdata;
  logic [TU-1:0]     m_segs_tuser;
  logic [VL-1:0]     m_segs_vlan;
  logic [3:0]        m_segs_nsegs;
  logic              m_segs_valid;
  logic              m_segs_ready;
  logic [31:0]       pkt_cnt;

  int tests = 0;
  int fails = 0;

  parser_seg_gather dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_segs_tdata  (m_segs_tdata),
    .m_segs_tuser  (m_segs_tuser),
    .m_segs_vlan   (m_segs_vlan),
    .m_segs_nsegs  (m_segs_nsegs),
    .m_segs_valid  (m_segs_valid),
    .m_segs_ready  (m_segs_ready),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int p, input int b);
    logic [31:0] w;
    w = {p[15:0], b[15:0]};
    return {8{w}};
  endfunction

  function automatic logic [TU-1:0] mku(input int p);
    logic [31:0] w;
    w = 32'hA5A50000 + p;
    return {4{w}};
  endfunction

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [W-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic [TU-1:0] u);
    bit ok;
    @(negedge axis_clk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      @(negedge axis_clk);
    end
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL handshake: observed tready stuck low, required handshake within 50 cycles");
    end
    @(posedge axis_clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_head(input string tag, input int n,
                            input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3,
                            input logic [TU-1:0] u);
    @(negedge axis_clk);
    chk({tag, ".valid"}, W'(m_segs_valid), W'(1'b1));
    chk({tag, ".nsegs"}, W'(m_segs_nsegs), W'(n));
    chk({tag, ".seg0"}, m_segs_tdata[0*W +: W], e0);
    chk({tag, ".seg1"}, m_segs_tdata[1*W +: W], e1);
    chk({tag, ".seg2"}, m_segs_tdata[2*W +: W], e2);
    chk({tag, ".seg3"}, m_segs_tdata[3*W +: W], e3);
    chk({tag, ".tuser"}, W'(m_segs_tuser), W'(u));
  endtask

  task automatic pop();
    m_segs_ready = 1'b1;
    @(posedge axis_clk);
    #1;
    m_segs_ready = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    @(negedge axis_clk);
    chk({tag, ".empty"}, W'(m_segs_valid), W'(1'b0));
  endtask

  localparam logic [KW-1:0] KALL = '1;

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] e;

    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_segs_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge axis_clk);
    chk("rst.tready", W'(s_axis_tready), W'(1'b1));
    chk("rst.valid", W'(m_segs_valid), W'(1'b0));
    chk("rst.pkt_cnt", W'(pkt_cnt), W'(32'd0));
    aresetn = 1'b1;

    // 6-beat packet: beats 0..3 gathered, 4..5 dropped
    for (int b = 0; b < 6; b++) begin
      send_beat(mk(1, b), KALL, (b == 5), (b == 0) ? mku(1) : mku(99));
    end
    check_head("p6", 4, mk(1, 0), mk(1, 1), mk(1, 2), mk(1, 3), mku(1));
    chk("p6.pkt_cnt", W'(pkt_cnt), W'(32'd1));
    pop();
    check_empty("p6");

    // 2-beat packet with partial keep on last beat
    send_beat(mk(2, 0), KALL, 1'b0, mku(2));
    send_beat(mk(2, 1), 32'h0000FFFF, 1'b1, mku(98));
    d = mk(2, 1);
    e = d & {{128{1'b0}}, {128{1'b1}}};
    check_head("p2", 2, mk(2, 0), e, '0, '0, mku(2));
    pop();

    // VLAN extraction from bytes 14..15
    d = mk(3, 0);
    d[119:112] = 8'h81;
    d[127:120] = 8'h23;
    send_beat(d, KALL, 1'b1, mku(3));
    check_head("vlan", 1, d, '0, '0, '0, mku(3));
    chk("vlan.id", W'(m_segs_vlan), W'(12'h123));
    chk("vlan.pkt_cnt", W'(pkt_cnt), W'(32'd3));
    pop();

    // Fill the FIFO with 16 entries, no pops
    for (int p = 20; p < 36; p++) begin
      send_beat(mk(p, 0), KALL, 1'b1, mku(p));
    end
    @(negedge axis_clk);
    chk("full.tready", W'(s_axis_tready), W'(1'b0));
    chk("full.pkt_cnt", W'(pkt_cnt), W'(32'd19));
    s_axis_tdata  = mk(36, 0);
    s_axis_tuser  = mku(36);
    s_axis_tkeep  = KALL;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (3) @(negedge axis_clk);
    chk("full.blocked_tready", W'(s_axis_tready), W'(1'b0));
    chk("full.blocked_cnt", W'(pkt_cnt), W'(32'd19));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check_head("full.h20", 1, mk(20, 0), '0, '0, '0, mku(20));
    pop();
    @(negedge axis_clk);
    chk("full.reenable", W'(s_axis_tready), W'(1'b1));
    send_beat(mk(36, 0), KALL, 1'b1, mku(36));
    chk("full.pkt_cnt17", W'(pkt_cnt), W'(32'd20));
    for (int p = 21; p < 37; p++) begin
      check_head($sformatf("full.h%0d", p), 1, mk(p, 0), '0, '0, '0, mku(p));
      pop();
    end
    check_empty("full");

    // Back-to-back 1-beat packets with consumer always ready
    @(negedge axis_clk);
    m_segs_ready  = 1'b1;
    s_axis_tkeep  = KALL;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = mku(60);
    s_axis_tdata  = mk(60, 0);
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge axis_clk);
      @(negedge axis_clk);
      chk($sformatf("b2b%0d.valid", k), W'(m_segs_valid), W'(1'b1));
      chk($sformatf("b2b%0d.tready", k), W'(s_axis_tready), W'(1'b1));
      chk($sformatf("b2b%0d.nsegs", k), W'(m_segs_nsegs), W'(4'd1));
      chk($sformatf("b2b%0d.seg0", k), m_segs_tdata[0 +: W], mk(60 + k, 0));
      if (k < 7) begin
        s_axis_tdata = mk(61 + k, 0);
        s_axis_tuser = mku(61 + k);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
    end
    @(posedge axis_clk);
    @(negedge axis_clk);
    chk("b2b.drained", W'(m_segs_valid), W'(1'b0));
    chk("b2b.pkt_cnt", W'(pkt_cnt), W'(32'd28));
    m_segs_ready = 1'b0;

    // Reset during beat 2 of a 4-beat packet
    send_beat(mk(40, 0), KALL, 1'b0, mku(40));
    send_beat(mk(40, 1), KALL, 1'b0, mku(97));
    @(negedge axis_clk);
    s_axis_tdata  = mk(40, 2);
    s_axis_tvalid = 1'b1;
    aresetn       = 1'b0;
    #1;
    chk("rst2.tready", W'(s_axis_tready), W'(1'b1));
    chk("rst2.valid", W'(m_segs_valid), W'(1'b0));
    chk("rst2.pkt_cnt", W'(pkt_cnt), W'(32'd0));
    @(negedge axis_clk);
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    aresetn = 1'b1;
    @(negedge axis_clk);
    chk("rst2.no_entry", W'(m_segs_valid), W'(1'b0));
    for (int b = 0; b < 3; b++) begin
      send_beat(mk(50, b), KALL, (b == 2), (b == 0) ? mku(50) : mku(96));
    end
    check_head("rst2.next", 3, mk(50, 0), mk(50, 1), mk(50, 2), '0, mku(50));
    chk("rst2.next_cnt", W'(pkt_cnt), W'(32'd1));
    pop();
    check_empty("rst2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
